// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and mul/div sequencer state encoding for the register-file
// write scheduler, the register file and ID-stage control.
package regfile_write_scheduler_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // Mul/div sequencer states: no operation, operation in flight, result
  // waiting for the shared write port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } md_state_e;

endpackage

// File: rtl/regfile_write_scheduler_reg_busy_table.sv
// Per-register busy scoreboard for multi-cycle mul/div destinations.
// One set port (issue), one clear port (result written) and three
// combinational read ports (two sources plus destination of the ID
// instruction). Register 0 never reads as busy.
module reg_busy_table #(
  parameter int NREG = regfile_write_scheduler_pkg::NREG,
  parameter int AW   = regfile_write_scheduler_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  input  logic [AW-1:0] rd_addr_c,
  output logic          rd_busy_a,
  output logic          rd_busy_b,
  output logic          rd_busy_c
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Next busy vector: clear first so a same-address set wins; bit 0 stays 0.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Busy state register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign rd_busy_a = busy_q[rd_addr_a];
  assign rd_busy_b = busy_q[rd_addr_b];
  assign rd_busy_c = busy_q[rd_addr_c];

endmodule

// File: rtl/regfile_write_scheduler.sv
// Register-file write scheduler: tracks busy mul/div destinations, sequences
// the external mul/div unit, arbitrates the single register-file write port
// (pipeline writeback first, mul/div result second) and raises the ID stall.
//
// Handshake: md_start is a one-cycle registered pulse that commits an issue;
// md_done is a one-cycle pulse from the unit and is only accepted in RUN.
// A result that collides with pipeline writeback is parked in a hold buffer
// and written in the first cycle the port is free.
module regfile_write_scheduler #(
  parameter int NREG = regfile_write_scheduler_pkg::NREG,
  parameter int AW   = regfile_write_scheduler_pkg::AW,
  parameter int DW   = regfile_write_scheduler_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic          id_flush,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_we,
  input  logic [AW-1:0] id_wa,
  input  logic          id_is_md,
  input  logic          ex_is_load,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_wa,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_wa,
  input  logic [DW-1:0] wb_wd,
  input  logic          md_done,
  input  logic [DW-1:0] md_result,
  output logic          md_start,
  output logic [AW-1:0] md_wa,
  output logic          md_busy,
  output logic          stall,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic [1:0]    dbg_state
);

  import regfile_write_scheduler_pkg::*;

  md_state_e     state;
  logic [DW-1:0] hold_q;

  logic busy_rs, busy_rt, busy_wa;
  logic rs_hit, rt_hit;
  logic load_use, raw_hz, waw_hz, struct_hz;
  logic issue;
  logic md_write;

  reg_busy_table #(
    .NREG (NREG),
    .AW   (AW)
  ) u_busy (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue && (id_wa != '0)),
    .set_addr  (id_wa),
    .clr_en    (md_write),
    .clr_addr  (md_wa),
    .rd_addr_a (id_rs),
    .rd_addr_b (id_rt),
    .rd_addr_c (id_wa),
    .rd_busy_a (busy_rs),
    .rd_busy_b (busy_rt),
    .rd_busy_c (busy_wa)
  );

  // Hazard detection against EX load, busy scoreboard and the mul/div unit.
  always_comb begin
    rs_hit    = id_use_rs && (id_rs != '0);
    rt_hit    = id_use_rt && (id_rt != '0);
    load_use  = ex_is_load && ex_we && (ex_wa != '0) &&
                ((rs_hit && (ex_wa == id_rs)) || (rt_hit && (ex_wa == id_rt)));
    raw_hz    = (rs_hit && busy_rs) || (rt_hit && busy_rt);
    waw_hz    = id_we && (id_wa != '0) && busy_wa;
    struct_hz = id_is_md && (state != ST_IDLE);
    stall     = id_valid && !id_flush && (load_use || raw_hz || waw_hz || struct_hz);
    issue     = id_valid && !id_flush && id_is_md && id_we && !stall;
  end

  // Write-port arbitration: writeback first, then a fresh or held mul/div result.
  always_comb begin
    md_write = !wb_we && (((state == ST_RUN) && md_done) || (state == ST_HOLD));
    rf_we    = 1'b0;
    rf_wa    = wb_wa;
    rf_wd    = wb_wd;
    if (wb_we) begin
      rf_we = (wb_wa != '0);
    end else if (md_write) begin
      rf_we = (md_wa != '0);
      rf_wa = md_wa;
      rf_wd = (state == ST_HOLD) ? hold_q : md_result;
    end
  end

  // Mul/div sequencer with registered start pulse, destination and hold buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      md_start <= 1'b0;
      md_wa    <= '0;
      hold_q   <= '0;
    end else begin
      md_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            state    <= ST_RUN;
            md_start <= 1'b1;
            md_wa    <= id_wa;
          end
        end
        ST_RUN: begin
          if (md_done) begin
            if (wb_we) begin
              hold_q <= md_result;
              state  <= ST_HOLD;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (!wb_we) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign md_busy   = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: hazard vector table, directed multi-cycle
// sequences and randomized traffic against a behavioural model.
module tb_regfile_write_scheduler;

  typedef struct {
    logic        id_valid;
    logic        id_flush;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        use_rs;
    logic        use_rt;
    logic        id_we;
    logic [4:0]  id_wa;
    logic        is_md;
    logic        ex_is_load;
    logic        ex_we;
    logic [4:0]  ex_wa;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        md_done;
    logic [31:0] md_result;
  } in_t;

  typedef struct {
    in_t        in;
    logic       exp_stall;
    logic       exp_rf_we;
    logic [4:0] exp_rf_wa;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        id_valid, id_flush, id_use_rs, id_use_rt, id_we, id_is_md;
  logic [4:0]  id_rs, id_rt, id_wa;
  logic        ex_is_load, ex_we;
  logic [4:0]  ex_wa;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        md_done;
  logic [31:0] md_result;
  logic        md_start, md_busy, stall, rf_we;
  logic [4:0]  md_wa, rf_wa;
  logic [31:0] rf_wd;
  logic [1:0]  dbg_state;

  regfile_write_scheduler dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_flush(id_flush), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_we(id_we), .id_wa(id_wa),
    .id_is_md(id_is_md), .ex_is_load(ex_is_load), .ex_we(ex_we), .ex_wa(ex_wa),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .md_done(md_done), .md_result(md_result),
    .md_start(md_start), .md_wa(md_wa), .md_busy(md_busy), .stall(stall),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One outstanding mul/div operation at most; its result waits in a queue
  // until the write port is free.
  bit          busy_m[32];
  bit          op_active;
  logic [31:0] res_q[$];
  logic [4:0]  m_wa;
  bit          start_m;

  task automatic model_reset();
    foreach (busy_m[i]) busy_m[i] = 1'b0;
    op_active = 1'b0;
    res_q.delete();
    m_wa    = '0;
    start_m = 1'b0;
  endtask

  // ---------------- driver ----------------
  function automatic in_t idle_in();
    in_t x;
    x.id_valid = 0; x.id_flush = 0; x.id_rs = 0; x.id_rt = 0;
    x.use_rs = 0; x.use_rt = 0; x.id_we = 0; x.id_wa = 0; x.is_md = 0;
    x.ex_is_load = 0; x.ex_we = 0; x.ex_wa = 0;
    x.wb_we = 0; x.wb_wa = 0; x.wb_wd = 0; x.md_done = 0; x.md_result = 0;
    return x;
  endfunction

  function automatic in_t mk(input logic v, input logic f, input logic [4:0] rs,
                             input logic urs, input logic [4:0] rt, input logic urt,
                             input logic ld, input logic exwe, input logic [4:0] exwa,
                             input logic wbwe, input logic [4:0] wbwa);
    in_t x = idle_in();
    x.id_valid = v; x.id_flush = f; x.id_rs = rs; x.use_rs = urs;
    x.id_rt = rt; x.use_rt = urt; x.ex_is_load = ld; x.ex_we = exwe;
    x.ex_wa = exwa; x.wb_we = wbwe; x.wb_wa = wbwa; x.wb_wd = 32'hC0DE_0000 | 32'(wbwa);
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.id_valid   = ($urandom_range(0, 9) < 8);
    x.id_flush   = ($urandom_range(0, 9) == 0);
    x.id_rs      = 5'($urandom_range(0, 7));
    x.id_rt      = 5'($urandom_range(0, 7));
    x.use_rs     = ($urandom_range(0, 3) != 0);
    x.use_rt     = ($urandom_range(0, 1) != 0);
    x.id_we      = ($urandom_range(0, 3) != 0);
    x.id_wa      = 5'($urandom_range(0, 7));
    x.is_md      = ($urandom_range(0, 9) < 3);
    x.ex_is_load = ($urandom_range(0, 9) < 3);
    x.ex_we      = ($urandom_range(0, 3) != 0);
    x.ex_wa      = 5'($urandom_range(0, 7));
    x.wb_we      = ($urandom_range(0, 1) != 0);
    x.wb_wa      = 5'($urandom_range(0, 31));
    x.wb_wd      = $urandom;
    x.md_done    = ($urandom_range(0, 9) < 2);
    x.md_result  = $urandom;
    return x;
  endfunction

  task automatic drive(input in_t x);
    id_valid = x.id_valid; id_flush = x.id_flush; id_rs = x.id_rs; id_rt = x.id_rt;
    id_use_rs = x.use_rs; id_use_rt = x.use_rt; id_we = x.id_we; id_wa = x.id_wa;
    id_is_md = x.is_md; ex_is_load = x.ex_is_load; ex_we = x.ex_we; ex_wa = x.ex_wa;
    wb_we = x.wb_we; wb_wa = x.wb_wa; wb_wd = x.wb_wd;
    md_done = x.md_done; md_result = x.md_result;
  endtask

  // One clock: drive after the falling edge, compare against the model,
  // then advance the model to the state after the next rising edge.
  task automatic cycle(input in_t x);
    logic lu, raw, waw, str, e_stall, arrival, mdw, e_we, issue;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    @(negedge clk);
    drive(x);
    #1;
    lu = x.ex_is_load && x.ex_we && (x.ex_wa != 0) &&
         ((x.use_rs && x.id_rs != 0 && x.id_rs == x.ex_wa) ||
          (x.use_rt && x.id_rt != 0 && x.id_rt == x.ex_wa));
    raw = (x.use_rs && x.id_rs != 0 && busy_m[x.id_rs]) ||
          (x.use_rt && x.id_rt != 0 && busy_m[x.id_rt]);
    waw = x.id_we && x.id_wa != 0 && busy_m[x.id_wa];
    str = x.is_md && op_active;
    e_stall = x.id_valid && !x.id_flush && (lu || raw || waw || str);
    arrival = op_active && (res_q.size() == 0) && x.md_done;
    mdw     = op_active && !x.wb_we && (res_q.size() > 0 || arrival);
    e_we = 1'b0; e_wa = '0; e_wd = '0;
    if (x.wb_we) begin
      e_we = (x.wb_wa != 0); e_wa = x.wb_wa; e_wd = x.wb_wd;
    end else if (mdw) begin
      e_we = (m_wa != 0); e_wa = m_wa;
      e_wd = (res_q.size() > 0) ? res_q[0] : x.md_result;
    end
    chk("stall", stall, e_stall);
    chk("rf_we", rf_we, e_we);
    if (e_we) begin
      chk("rf_wa", rf_wa, e_wa);
      chk("rf_wd", rf_wd, e_wd);
    end
    chk("md_start", md_start, start_m);
    chk("md_busy", md_busy, op_active);
    chk("md_wa", md_wa, m_wa);
    // advance model across the rising edge
    issue = x.id_valid && !x.id_flush && x.is_md && x.id_we && !e_stall;
    if (mdw) begin
      busy_m[m_wa] = 1'b0;
      op_active    = 1'b0;
      res_q.delete();
    end else if (arrival) begin
      res_q.push_back(x.md_result);
    end
    start_m = issue;
    if (issue) begin
      op_active = 1'b1;
      m_wa      = x.id_wa;
      if (x.id_wa != 0) busy_m[x.id_wa] = 1'b1;
    end
  endtask

  // ---------------- test ----------------
  vec_t vt[11];
  in_t  x;

  initial begin
    // combinational hazard table, applied with no mul/div in flight
    //          v  f  rs  urs rt  urt ld we exwa wbwe wbwa     stall we wa
    vt[0]  = '{mk(1, 0, 5, 1, 0, 0, 1, 1, 5, 0, 0), 1, 0, 0};
    vt[1]  = '{mk(1, 0, 0, 1, 0, 0, 1, 1, 5, 0, 0), 0, 0, 0};
    vt[2]  = '{mk(1, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0), 0, 0, 0};
    vt[3]  = '{mk(1, 0, 1, 1, 9, 1, 1, 1, 9, 0, 0), 1, 0, 0};
    vt[4]  = '{mk(1, 0, 5, 0, 0, 0, 1, 1, 5, 0, 0), 0, 0, 0};
    vt[5]  = '{mk(1, 0, 5, 1, 0, 0, 0, 1, 5, 0, 0), 0, 0, 0};
    vt[6]  = '{mk(1, 0, 5, 1, 0, 0, 1, 0, 5, 0, 0), 0, 0, 0};
    vt[7]  = '{mk(1, 1, 5, 1, 0, 0, 1, 1, 5, 0, 0), 0, 0, 0};
    vt[8]  = '{mk(0, 0, 5, 1, 0, 0, 1, 1, 5, 0, 0), 0, 0, 0};
    vt[9]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3), 0, 1, 3};
    vt[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0};

    model_reset();
    drive(idle_in());
    rst = 1'b0;
    #12;
    chk("reset_md_start", md_start, 0);
    chk("reset_md_busy", md_busy, 0);
    chk("reset_md_wa", md_wa, 0);
    chk("reset_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].in);
      #1;
      chk($sformatf("vec%0d_stall", i), stall, vt[i].exp_stall);
      chk($sformatf("vec%0d_rf_we", i), rf_we, vt[i].exp_rf_we);
      if (vt[i].exp_rf_we) begin
        chk($sformatf("vec%0d_rf_wa", i), rf_wa, vt[i].exp_rf_wa);
        chk($sformatf("vec%0d_rf_wd", i), rf_wd, vt[i].in.wb_wd);
      end
    end

    // load-use lasts only while EX holds the load
    cycle(mk(1, 0, 5, 1, 0, 0, 1, 1, 5, 0, 0));
    chk("lu_stall_1", stall, 1);
    cycle(mk(1, 0, 5, 1, 0, 0, 0, 1, 7, 0, 0));
    chk("lu_stall_2", stall, 0);

    // mul to $8
    x = idle_in(); x.id_valid = 1; x.is_md = 1; x.id_we = 1; x.id_wa = 8;
    cycle(x);
    x = idle_in(); x.id_valid = 1; x.id_rs = 8; x.use_rs = 1; x.id_we = 1; x.id_wa = 10;
    cycle(x);
    chk("mul_start", md_start, 1);
    chk("mul_wa", md_wa, 8);
    chk("mul_raw_stall", stall, 1);
    cycle(x);
    chk("mul_start_once", md_start, 0);
    x = idle_in(); x.id_valid = 1; x.is_md = 1; x.id_we = 1; x.id_wa = 9;
    cycle(x);
    chk("struct_stall", stall, 1);
    x = idle_in(); x.id_valid = 1; x.id_we = 1; x.id_wa = 8;
    cycle(x);
    chk("waw_stall", stall, 1);
    x = idle_in(); x.id_valid = 1; x.id_rs = 8; x.use_rs = 1;
    x.md_done = 1; x.md_result = 32'h1234;
    cycle(x);
    chk("done_rf_we", rf_we, 1);
    chk("done_rf_wa", rf_wa, 8);
    chk("done_rf_wd", rf_wd, 32'h1234);
    x.md_done = 0;
    cycle(x);
    chk("done_busy_clear", stall, 0);
    chk("done_md_busy", md_busy, 0);

    // port conflict: result parked while writeback owns the port
    x = idle_in(); x.id_valid = 1; x.is_md = 1; x.id_we = 1; x.id_wa = 8;
    cycle(x);
    x = idle_in(); x.wb_we = 1; x.wb_wa = 3; x.wb_wd = 32'hAA;
    x.md_done = 1; x.md_result = 32'h5678;
    cycle(x);
    chk("conf_wb_wa_1", rf_wa, 3);
    chk("conf_wb_wd_1", rf_wd, 32'hAA);
    x.md_done = 0;
    cycle(x);
    chk("conf_wb_wa_2", rf_wa, 3);
    cycle(idle_in());
    chk("conf_hold_we", rf_we, 1);
    chk("conf_hold_wa", rf_wa, 8);
    chk("conf_hold_wd", rf_wd, 32'h5678);
    cycle(idle_in());
    chk("conf_idle", md_busy, 0);

    // reset while a result is held
    x = idle_in(); x.id_valid = 1; x.is_md = 1; x.id_we = 1; x.id_wa = 8;
    cycle(x);
    x = idle_in(); x.wb_we = 1; x.wb_wa = 3; x.md_done = 1; x.md_result = 32'h9999;
    cycle(x);
    @(negedge clk);
    x = idle_in(); x.wb_we = 1; x.wb_wa = 3;
    drive(x);
    #2 rst = 1'b0;
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_md_busy", md_busy, 0);
    chk("rst_md_start", md_start, 0);
    chk("rst_md_wa", md_wa, 0);
    x = idle_in(); x.id_valid = 1; x.id_rs = 8; x.use_rs = 1;
    drive(x);
    #1;
    chk("rst_busy_clear", stall, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cycle(idle_in());
    chk("rst_no_held_write", rf_we, 0);
    cycle(idle_in());
    chk("rst_no_held_write_2", rf_we, 0);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      cycle(rand_in());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Sits between the ID stage, the writeback stage and the register file.
- Owns a per-register busy scoreboard for multi-cycle mul/div results.
- Sequences the external mul/div unit and issues its start pulse.
- Arbitrates the single register-file write port between pipeline writeback and mul/div results, and raises the ID-stage stall for load-use, RAW/WAW-on-busy and structural hazards.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  ID stage holds a valid instruction.
- id_flush  in  1  ID instruction is being squashed; suppresses issue.
- id_rs  in  AW  source register 1.
- id_rt  in  AW  source register 2.
- id_use_rs  in  1  id_rs is read.
- id_use_rt  in  1  id_rt is read.
- id_we  in  1  instruction writes a register.
- id_wa  in  AW  destination register.
- id_is_md  in  1  instruction is a multi-cycle mul/div.
- ex_is_load  in  1  EX stage holds a load.
- ex_we  in  1  EX stage writes a register.
- ex_wa  in  AW  EX destination register.
- wb_we  in  1  pipeline writeback request.
- wb_wa  in  AW  writeback address.
- wb_wd  in  DW  writeback data.
- md_done  in  1  mul/div result valid, single-cycle pulse.
- md_result  in  DW  mul/div result.
- md_start  out  1  registered start pulse to the mul/div unit.
- md_wa  out  AW  latched mul/div destination register.
- md_busy  out  1  FSM not IDLE.
- stall  out  1  freeze PC/IF/ID; insert a bubble into EX.
- rf_we  out  1  register-file write enable.
- rf_wa  out  AW  register-file write address.
- rf_wd  out  DW  register-file write data.

Behaviour:
- Reset (rst low, async):
  - busy[] all 0; FSM IDLE; md_start 0; md_wa 0; hold buffer 0.
  - Combinational outputs follow: stall 0 unless the load-use condition holds; rf_we = wb_we.
- Register 0:
  - Never marked busy and never a hazard source.
  - rf_we is forced 0 when the selected address is 0.
- Hazard terms, all combinational:
  - rs_hit = id_use_rs & id_rs!=0; rt_hit likewise.
  - Load-use: ex_is_load & ex_we & ex_wa!=0 & ((rs_hit & ex_wa==id_rs) | (rt_hit & ex_wa==id_rt)).
  - Busy RAW: (rs_hit & busy[id_rs]) | (rt_hit & busy[id_rt]).
  - Busy WAW: id_we & id_wa!=0 & busy[id_wa].
  - Structural: id_is_md & state!=IDLE.
  - stall = id_valid & ~id_flush & (load-use | RAW | WAW | structural).
- Issue: when id_valid & ~id_flush & id_is_md & id_we & ~stall at edge t:
  - md_start=1 for exactly one cycle after t; md_wa=id_wa.
  - busy[id_wa] set (unless id_wa is 0); state moves to RUN.
- FSM states: IDLE, RUN, HOLD.
  - IDLE -> RUN on issue.
  - RUN: on md_done with wb_we=0, drive rf_we=1, rf_wa=md_wa, rf_wd=md_result in the same cycle; clear busy[md_wa]; go to IDLE.
  - RUN: on md_done with wb_we=1, writeback wins; latch md_result into the hold buffer; go to HOLD.
  - HOLD: in the first cycle with wb_we=0, write the hold buffer to md_wa; clear busy; go to IDLE.
  - md_done outside RUN is ignored.
- Write arbitration: pipeline writeback always has priority. Because busy[md_wa] is set, the pipeline can never target md_wa before it clears, so no ordering conflict arises.
- Busy-clear and new issue in the same cycle: cannot happen, since the structural stall holds while state!=IDLE. busy is cleared at the edge ending the write cycle.
- A flush never affects an issued mul/div; issue is committed.
- Reset mid-operation (RUN/HOLD): the result is lost, all busy bits cleared, FSM returns to IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE/RUN/HOLD, 2 bits) and AW/DW/NREG constants, reused by the register file and ID control.
- One natural sub-module: reg_busy_table.
  - 32-bit busy vector with set port, clear port and three read ports.
  - Bit 0 is hardwired to 0.
  - Set and clear to the same address in one cycle resolves to set.

Test Plan:
- Load-use: EX lw to $5, ID add reading $5 -> stall=1 for one cycle, 0 next cycle once EX moves on. Same case with id_rs=$0 -> stall=0.
- Mul/div issue: mul to $8 issued at cycle 10 -> md_start=1 only in cycle 11, md_wa=8, busy[8]=1; ID reading $8 stalls until md_done.
- Done with free port: md_done with md_result=0x1234 and wb_we=0 -> rf_we=1, rf_wa=8, rf_wd=0x1234 that cycle; busy[8]=0 and md_busy=0 next cycle.
- Port conflict: md_done while wb_we=1 (wb_wa=3, data 0xAA) for 2 cycles -> writes 0xAA to $3 both cycles; the hold-buffered result is written to $8 in the first cycle wb_we=0; state HOLD->IDLE.
- Structural and WAW: second mul in ID while RUN -> stall=1; add writing $8 while busy[8] -> stall=1.
- Reset: drop rst during HOLD -> state IDLE, busy all 0, md_start 0, no rf write of the held result after rst returns high.
